// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, the "no producer" tag, RS classes and default sizes.
package tomasulo_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_SD  = 3'b011;

  localparam int TAG_NONE = 0;
  localparam int N_REGS   = 8;

  localparam int D_N_ADD = 3;
  localparam int D_N_MEM = 2;
  localparam int D_TAG_W = 3;

  typedef enum logic {CLS_ADD, CLS_MEM} cls_e;

  function automatic logic op_legal(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic cls_e op_class(input logic [2:0] op);
    return op[1] ? CLS_MEM : CLS_ADD;
  endfunction

endpackage

// File: rtl/free_slot_picker.sv
// Lowest-index priority encoder over a busy vector: reports whether any slot is free and which.
module free_slot_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_busy,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  // Scan downward so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!i_busy[i]) begin
        o_found = 1'b1;
        o_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Tomasulo issue stage: allocates adder/mem RS entries, renames through Qi, frees on CDB/store done.
// Optional macro STALL_COUNT_EN adds a saturating stall_cycles counter output.
module issue_scheduler
  import tomasulo_pkg::*;
#(
  parameter int N_ADD = D_N_ADD,
  parameter int N_MEM = D_N_MEM,
  parameter int TAG_W = D_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [2:0]       opcode,
  input  logic [2:0]       RX,
  input  logic [2:0]       RY,
  input  logic [2:0]       RZ,
  input  logic [3:0]       immediate,
  output logic             stall,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             st_done_valid,
  input  logic [TAG_W-1:0] st_done_tag,
  output logic             issue_valid,
  output logic [TAG_W-1:0] issue_tag,
  output logic [2:0]       issue_op,
  output logic [TAG_W-1:0] issue_qj,
  output logic [TAG_W-1:0] issue_qk,
  output logic [2:0]       issue_rj,
  output logic [2:0]       issue_rk,
  output logic [3:0]       issue_imm,
  output logic             illegal_op
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  localparam int N_ENT = N_ADD + N_MEM;
  localparam int AIW   = (N_ADD > 1) ? $clog2(N_ADD) : 1;
  localparam int MIW   = (N_MEM > 1) ? $clog2(N_MEM) : 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [2:0]       rj;
    logic [2:0]       rk;
    logic [3:0]       imm;
  } issue_t;

  logic [N_ENT-1:0]                r_busy;
  logic [N_REGS-1:0][TAG_W-1:0]    r_qi;
  issue_t                          r_iss;
  logic                            r_iss_vld;
  logic                            r_ill;

  logic                            w_add_found, w_mem_found, w_found;
  logic [AIW-1:0]                  w_add_idx;
  logic [MIW-1:0]                  w_mem_idx;
  logic                            w_legal, w_fire, w_renames, w_cdb_ok;
  cls_e                            w_cls;
  logic [TAG_W-1:0]                w_tag;
  logic [N_ENT-1:0]                w_cdb_clr, w_st_clr, w_set;
  logic [N_REGS-1:0][TAG_W-1:0]    w_qi_nxt;
  issue_t                          w_iss;

  free_slot_picker #(.N(N_ADD), .IW(AIW)) u_add_pick (
    .i_busy  (r_busy[N_ADD-1:0]),
    .o_found (w_add_found),
    .o_idx   (w_add_idx)
  );

  free_slot_picker #(.N(N_MEM), .IW(MIW)) u_mem_pick (
    .i_busy  (r_busy[N_ENT-1:N_ADD]),
    .o_found (w_mem_found),
    .o_idx   (w_mem_idx)
  );

  // A producer finishing this cycle makes its operand ready: read the register file instead.
  function automatic logic [TAG_W-1:0] fwd(input logic [TAG_W-1:0] q, input logic hit,
                                           input logic [TAG_W-1:0] tag);
    return (hit && q == tag) ? TAG_W'(TAG_NONE) : q;
  endfunction

  assign w_legal   = op_legal(opcode);
  assign w_cls     = op_class(opcode);
  assign w_found   = (w_cls == CLS_MEM) ? w_mem_found : w_add_found;
  assign stall     = instr_valid & w_legal & ~w_found;
  assign w_fire    = instr_valid & w_legal & w_found;
  assign w_renames = w_fire & (opcode != OP_SD);
  assign w_tag     = (w_cls == CLS_MEM) ? TAG_W'(N_ADD + 1) + TAG_W'(w_mem_idx)
                                        : TAG_W'(1) + TAG_W'(w_add_idx);

  // Tag 0, out-of-range tags and tags of idle entries decode to no hit and are ignored.
  always_comb begin
    w_cdb_clr = '0;
    w_st_clr  = '0;
    w_set     = '0;
    for (int i = 0; i < N_ENT; i++) begin
      w_cdb_clr[i] = cdb_valid && (cdb_tag == TAG_W'(i + 1)) && r_busy[i];
      w_st_clr[i]  = st_done_valid && (st_done_tag == TAG_W'(i + 1)) && r_busy[i];
      w_set[i]     = w_fire && (w_tag == TAG_W'(i + 1));
    end
  end

  assign w_cdb_ok = |w_cdb_clr;

  always_comb begin
    w_iss     = '0;
    w_iss.op  = opcode;
    w_iss.tag = w_tag;
    w_iss.imm = immediate;
    w_iss.rj  = RY;
    w_iss.qj  = fwd(r_qi[RY], w_cdb_ok, cdb_tag);
    case (opcode)
      OP_LD:   w_iss.rk = 3'd0;
      OP_SD:   w_iss.rk = RX;
      default: w_iss.rk = RZ;
    endcase
    w_iss.qk  = (opcode == OP_LD) ? TAG_W'(TAG_NONE) : fwd(r_qi[w_iss.rk], w_cdb_ok, cdb_tag);
  end

  // Broadcast clears first; the rename write then overrides its own destination.
  always_comb begin
    w_qi_nxt = r_qi;
    for (int r = 0; r < N_REGS; r++)
      if (w_cdb_ok && r_qi[r] == cdb_tag) w_qi_nxt[r] = TAG_W'(TAG_NONE);
    if (w_renames) w_qi_nxt[RX] = w_tag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy    <= '0;
      r_qi      <= '0;
      r_iss     <= '0;
      r_iss_vld <= 1'b0;
      r_ill     <= 1'b0;
    end else begin
      r_busy    <= (r_busy & ~w_cdb_clr & ~w_st_clr) | w_set;
      r_qi      <= w_qi_nxt;
      r_iss_vld <= w_fire;
      r_ill     <= instr_valid & ~w_legal;
      if (w_fire) r_iss <= w_iss;
    end
  end

  assign issue_valid = r_iss_vld;
  assign issue_tag   = r_iss.tag;
  assign issue_op    = r_iss.op;
  assign issue_qj    = r_iss.qj;
  assign issue_qk    = r_iss.qk;
  assign issue_rj    = r_iss.rj;
  assign issue_rk    = r_iss.rk;
  assign issue_imm   = r_iss.imm;
  assign illegal_op  = r_ill;

`ifdef STALL_COUNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clock) begin
    if (reset)                              r_stall_cnt <= '0;
    else if (stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed vector bench for issue_scheduler: table of per-cycle stimulus with expected results, plus reset sequences.
module tb_issue_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [2:0] opcode, RX, RY, RZ;
  logic [3:0] immediate;
  logic       stall;
  logic       cdb_valid;
  logic [2:0] cdb_tag;
  logic       st_done_valid;
  logic [2:0] st_done_tag;
  logic       issue_valid;
  logic [2:0] issue_tag, issue_op, issue_qj, issue_qk, issue_rj, issue_rk;
  logic [3:0] issue_imm;
  logic       illegal_op;
`ifdef STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  issue_scheduler dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .RX(RX), .RY(RY), .RZ(RZ), .immediate(immediate), .stall(stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .st_done_valid(st_done_valid), .st_done_tag(st_done_tag),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_op(issue_op),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rj(issue_rj), .issue_rk(issue_rk),
    .issue_imm(issue_imm), .illegal_op(illegal_op)
`ifdef STALL_COUNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic       iv;
    logic [2:0] op, rx, ry, rz;
    logic [3:0] imm;
    logic       cv;
    logic [2:0] ct;
    logic       sv;
    logic [2:0] st;
    logic       e_stall, e_iv;
    logic [2:0] e_tag, e_qj, e_qk, e_rj, e_rk;
    logic [3:0] e_imm;
    logic       e_ill;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int iv, int op, int rx, int ry, int rz, int imm,
                              int cv, int ct, int sv, int st,
                              int es, int eiv, int etag, int eqj, int eqk,
                              int erj, int erk, int eimm, int eill);
    vec_t v;
    v.iv = iv[0]; v.op = op[2:0]; v.rx = rx[2:0]; v.ry = ry[2:0]; v.rz = rz[2:0];
    v.imm = imm[3:0]; v.cv = cv[0]; v.ct = ct[2:0]; v.sv = sv[0]; v.st = st[2:0];
    v.e_stall = es[0]; v.e_iv = eiv[0]; v.e_tag = etag[2:0]; v.e_qj = eqj[2:0];
    v.e_qk = eqk[2:0]; v.e_rj = erj[2:0]; v.e_rk = erk[2:0]; v.e_imm = eimm[3:0];
    v.e_ill = eill[0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    instr_valid = v.iv; opcode = v.op; RX = v.rx; RY = v.ry; RZ = v.rz;
    immediate = v.imm; cdb_valid = v.cv; cdb_tag = v.ct;
    st_done_valid = v.sv; st_done_tag = v.st;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, " issue_valid"}, int'(issue_valid), 0);
    chk({pfx, " illegal_op"},  int'(illegal_op),  0);
    chk({pfx, " issue_tag"},   int'(issue_tag),   0);
    chk({pfx, " issue_op"},    int'(issue_op),    0);
    chk({pfx, " issue_qj"},    int'(issue_qj),    0);
    chk({pfx, " issue_qk"},    int'(issue_qk),    0);
    chk({pfx, " issue_rj"},    int'(issue_rj),    0);
    chk({pfx, " issue_rk"},    int'(issue_rk),    0);
    chk({pfx, " issue_imm"},   int'(issue_imm),   0);
  endtask

  initial begin
    //          iv op rx ry rz im cv ct sv st | st iv tg qj qk rj rk im il
    tv.push_back(mk(1, 1, 0, 1, 2, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1, 2, 0, 0)); // SUB R0,R1,R2
    tv.push_back(mk(1, 2, 1, 2, 5, 1, 0, 0, 0, 0,  0, 1, 4, 0, 0, 2, 0, 1, 0)); // LD R1,1(R2)
    tv.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0,  0, 1, 2, 1, 4, 0, 1, 0, 0)); // SUB R1,R0,R1
    tv.push_back(mk(1, 0, 5, 1, 1, 0, 0, 0, 0, 0,  0, 1, 3, 2, 2, 1, 1, 0, 0)); // ADD R5,R1,R1
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(1, 0, 6, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0)); // adders full
    tv.push_back(mk(1, 0, 6, 0, 0, 0, 1, 2, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0)); // CDB 2, still stalled
    tv.push_back(mk(1, 0, 6, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 1, 1, 0, 0, 0, 0)); // reuses tag 2
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0)); // CDB 3
    tv.push_back(mk(1, 0, 3, 0, 4, 0, 1, 1, 0, 0,  0, 1, 3, 0, 0, 0, 4, 0, 0)); // bypass R0
    tv.push_back(mk(1, 0, 7, 0, 5, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 5, 0, 0)); // R0,R5 cleared
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0)); // CDB 3
    tv.push_back(mk(1, 0, 6, 6, 6, 0, 1, 2, 0, 0,  0, 1, 3, 0, 0, 6, 6, 0, 0)); // rename beats clear
    tv.push_back(mk(1, 0, 2, 6, 7, 0, 0, 0, 0, 0,  0, 1, 2, 3, 1, 6, 7, 0, 0)); // Qi[R6]=3
    tv.push_back(mk(1, 3, 1, 2, 0, 0, 0, 0, 0, 0,  0, 1, 5, 2, 0, 2, 1, 0, 0)); // SD R1,0(R2)
    tv.push_back(mk(1, 2, 4, 0, 0, 2, 0, 0, 1, 4,  1, 0, 0, 0, 0, 0, 0, 0, 0)); // mem full, st_done 4
    tv.push_back(mk(1, 2, 4, 0, 0, 2, 0, 0, 0, 0,  0, 1, 4, 0, 0, 0, 0, 2, 0)); // LD reuses 4
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0)); // st_done 5
    tv.push_back(mk(1, 3, 4, 1, 0, 3, 0, 0, 0, 0,  0, 1, 5, 0, 4, 1, 4, 3, 0)); // SD did not rename R1
    tv.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1)); // illegal, no stall
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0)); // bogus CDB tag 7
    tv.push_back(mk(1, 0, 1, 2, 3, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0)); // CDB tag 0 ignored
    tv.push_back(mk(1, 0, 1, 2, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0)); // still full

    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clock);
    #1;
    chk_outputs_zero("reset");
    chk("reset stall", int'(stall), 0);
`ifdef STALL_COUNT_EN
    chk("reset stall_cycles", int'(stall_cycles), 0);
`endif
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clock);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d stall", i), int'(stall), int'(tv[i].e_stall));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d issue_valid", i), int'(issue_valid), int'(tv[i].e_iv));
      chk($sformatf("v%0d illegal_op", i), int'(illegal_op), int'(tv[i].e_ill));
      if (tv[i].e_iv) begin
        chk($sformatf("v%0d issue_tag", i), int'(issue_tag), int'(tv[i].e_tag));
        chk($sformatf("v%0d issue_op", i),  int'(issue_op),  int'(tv[i].op));
        chk($sformatf("v%0d issue_qj", i),  int'(issue_qj),  int'(tv[i].e_qj));
        chk($sformatf("v%0d issue_qk", i),  int'(issue_qk),  int'(tv[i].e_qk));
        chk($sformatf("v%0d issue_rj", i),  int'(issue_rj),  int'(tv[i].e_rj));
        chk($sformatf("v%0d issue_rk", i),  int'(issue_rk),  int'(tv[i].e_rk));
        chk($sformatf("v%0d issue_imm", i), int'(issue_imm), int'(tv[i].e_imm));
      end
    end

`ifdef STALL_COUNT_EN
    chk("stall_cycles before reset", int'(stall_cycles), 9);
`endif

    // Reset while all five entries are busy and an ADD is stalled: ADD must not issue.
    @(negedge clock);
    reset = 1'b1;
    drive(mk(1, 0, 1, 2, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    chk_outputs_zero("midreset");
    chk("midreset stall", int'(stall), 0);
`ifdef STALL_COUNT_EN
    chk("midreset stall_cycles", int'(stall_cycles), 0);
`endif
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post-reset issue_valid", int'(issue_valid), 1);
    chk("post-reset issue_tag",   int'(issue_tag),   1);
    chk("post-reset issue_qj",    int'(issue_qj),    0);
    chk("post-reset issue_qk",    int'(issue_qk),    0);

    @(negedge clock);
    instr_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("idle issue_valid", int'(issue_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
